// File: rtl/nsr_pkg.sv
// Shared types and constants for the NSR leaky-integrate-and-fire write sequencer.
package nsr_pkg;

  localparam int NSR_LANES  = 16;
  localparam int NSR_DATA_W = 32;
  localparam int NSR_ADDR_W = 5;
  localparam int NSR_EXT_W  = NSR_DATA_W + 2;

  typedef logic signed [NSR_DATA_W-1:0] nsr_word_t;
  typedef logic signed [NSR_EXT_W-1:0]  nsr_ext_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } nsr_state_t;

  // Saturation bounds expressed at the widened intermediate width.
  localparam nsr_ext_t NSR_SAT_MAX = {3'b000, {(NSR_DATA_W-1){1'b1}}};
  localparam nsr_ext_t NSR_SAT_MIN = {3'b111, {(NSR_DATA_W-1){1'b0}}};

endpackage

// File: rtl/lif_lane.sv
// One combinational leaky-integrate-and-fire step for a single neuron.
module lif_lane
  import nsr_pkg::*;
(
  input  nsr_word_t  v,
  input  nsr_word_t  cur,
  input  nsr_word_t  vt,
  input  logic [4:0] leak_shift,
  output nsr_word_t  wd,
  output logic       spike
);

  nsr_ext_t v_x;
  nsr_ext_t cur_x;
  nsr_ext_t leak_x;
  nsr_ext_t t_x;
  nsr_ext_t sat_x;
  nsr_word_t sat_w;

  always_comb begin
    v_x    = {{2{v[NSR_DATA_W-1]}}, v};
    cur_x  = {{2{cur[NSR_DATA_W-1]}}, cur};
    leak_x = v_x >>> leak_shift;
    t_x    = v_x - leak_x + cur_x;
    if (t_x > NSR_SAT_MAX) begin
      sat_x = NSR_SAT_MAX;
    end else if (t_x < NSR_SAT_MIN) begin
      sat_x = NSR_SAT_MIN;
    end else begin
      sat_x = t_x;
    end
    // Threshold is compared against the clamped value, so a saturated word can still fire.
    sat_w = sat_x[NSR_DATA_W-1:0];
    spike = (sat_w >= vt);
    wd    = spike ? '0 : sat_w;
  end

endmodule

// File: rtl/nsr_lif_update.sv
// Reads a 16-neuron NSR window, computes one LIF step per lane, and writes results back one word per cycle.
module nsr_lif_update
  import nsr_pkg::*;
#(
  parameter int LANES  = NSR_LANES,
  parameter int DATA_W = NSR_DATA_W,
  parameter int ADDR_W = NSR_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base,
  input  logic [4:0]              leak_shift,
  output logic                    busy,
  output logic                    done,
  output logic [LANES-1:0]        spike_mask,
  output logic [ADDR_W-1:0]       nsr_ra,
  input  logic [LANES*DATA_W-1:0] cur_in,
  input  logic [LANES*DATA_W-1:0] vol_in,
  input  logic [DATA_W-1:0]       vt_in,
  output logic                    nsr_we,
  output logic [ADDR_W-1:0]       nsr_wa,
  output logic [DATA_W-1:0]       nsr_wd
);

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(LANES - 1);

  nsr_state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [4:0]        leak_q;
  logic [CNT_W-1:0]  k_q;
  logic [CNT_W-1:0]  k_nx;
  logic [DATA_W-1:0] res_q [LANES];
  logic [LANES-1:0]  mask_pend_q;
  logic [LANES-1:0]  spike_mask_q;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;

  logic [DATA_W-1:0] lane_wd [LANES];
  logic [LANES-1:0]  lane_spike;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lif_lane u_lane (
      .v          (vol_in[g*DATA_W +: DATA_W]),
      .cur        (cur_in[g*DATA_W +: DATA_W]),
      .vt         (vt_in),
      .leak_shift (leak_q),
      .wd         (lane_wd[g]),
      .spike      (lane_spike[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = WRITE;
      WRITE:   if (k_q == LAST_K) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign k_nx = k_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      leak_q       <= '0;
      k_q          <= '0;
      mask_pend_q  <= '0;
      spike_mask_q <= '0;
      we_q         <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
      for (int i = 0; i < LANES; i++) res_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= base;
            leak_q <= leak_shift;
          end
        end
        // Snapshot every lane here so write-back cannot feed into later lanes.
        LOAD: begin
          res_q       <= lane_wd;
          mask_pend_q <= lane_spike;
          we_q        <= 1'b1;
          wa_q        <= base_q;
          wd_q        <= lane_wd[0];
          k_q         <= '0;
        end
        WRITE: begin
          if (k_q == LAST_K) begin
            we_q         <= 1'b0;
            spike_mask_q <= mask_pend_q;
          end else begin
            k_q  <= k_nx;
            wa_q <= base_q + ADDR_W'(k_nx);
            wd_q <= res_q[k_nx];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q == LOAD) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign spike_mask = spike_mask_q;
  assign nsr_ra     = base_q;
  assign nsr_we     = we_q;
  assign nsr_wa     = wa_q;
  assign nsr_wd     = wd_q;

endmodule

// File: tb/tb_nsr_lif_update.sv
// Scoreboard bench for nsr_lif_update with a behavioural NSR and LIF reference model.
module tb_nsr_lif_update;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   base;
  logic [4:0]   leak_shift;
  logic         busy;
  logic         done;
  logic [15:0]  spike_mask;
  logic [4:0]   nsr_ra;
  logic [511:0] cur_in;
  logic [511:0] vol_in;
  logic [31:0]  vt_in;
  logic         nsr_we;
  logic [4:0]   nsr_wa;
  logic [31:0]  nsr_wd;

  nsr_lif_update dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .leak_shift (leak_shift),
    .busy       (busy),
    .done       (done),
    .spike_mask (spike_mask),
    .nsr_ra     (nsr_ra),
    .cur_in     (cur_in),
    .vol_in     (vol_in),
    .vt_in      (vt_in),
    .nsr_we     (nsr_we),
    .nsr_wa     (nsr_wa),
    .nsr_wd     (nsr_wd)
  );

  always #5 clk = ~clk;

  // Behavioural NSR: 32-entry arrays, windowed vector read with wrap, single-word write.
  logic [31:0] vol_mem [32];
  logic [31:0] cur_mem [32];
  logic [31:0] ld_vol  [32];
  logic [31:0] ld_cur  [32];
  logic        ld_en;

  always @(posedge clk) begin
    if (nsr_we) vol_mem[nsr_wa] <= nsr_wd;
    else if (ld_en) begin
      vol_mem <= ld_vol;
      cur_mem <= ld_cur;
    end
  end

  always_comb begin
    cur_in = '0;
    vol_in = '0;
    for (int i = 0; i < 16; i++) begin
      cur_in[i*32 +: 32] = cur_mem[5'(nsr_ra + 5'(i))];
      vol_in[i*32 +: 32] = vol_mem[5'(nsr_ra + 5'(i))];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [36:0] exp_wr [$];
  logic [15:0] exp_mask [$];
  logic [36:0] e_wr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Returns {spike, written_word} for one neuron using wide signed arithmetic.
  function automatic logic [32:0] ref_lif(input logic [31:0] v, input logic [31:0] c,
                                          input logic [31:0] th, input int sh);
    longint vs, cs, ts, t;
    bit sp;
    vs = longint'($signed(v));
    cs = longint'($signed(c));
    ts = longint'($signed(th));
    t  = vs - (vs >>> sh) + cs;
    if (t > SMAX) t = SMAX;
    else if (t < SMIN) t = SMIN;
    sp = (t >= ts);
    return {sp, sp ? 32'd0 : t[31:0]};
  endfunction

  task automatic push_expect(input logic [4:0] b, input logic [4:0] ls);
    logic [15:0] m;
    logic [4:0]  a;
    logic [32:0] r;
    m = '0;
    for (int k = 0; k < 16; k++) begin
      a = 5'(b + 5'(k));
      r = ref_lif(vol_mem[a], cur_mem[a], vt_in, int'(ls));
      exp_wr.push_back({a, r[31:0]});
      m[k] = r[32];
    end
    exp_mask.push_back(m);
  endtask

  // Monitor: checks every write and every completion against the queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      exp_wr.delete();
      exp_mask.delete();
      wr_cnt = 0;
    end else begin
      if (nsr_we) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", nsr_wa, nsr_wd);
        end else begin
          e_wr = exp_wr.pop_front();
          chk("write_addr", 64'(nsr_wa), 64'(e_wr[36:32]));
          chk("write_data", 64'(nsr_wd), 64'(e_wr[31:0]));
        end
      end
      if (done) begin
        done_cnt++;
        chk("writes_per_cmd", 64'(wr_cnt), 64'd16);
        wr_cnt = 0;
        chk("busy_at_done", 64'(busy), 64'd0);
        if (exp_mask.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: mask 0x%0h, expected no completion", spike_mask);
        end else begin
          chk("spike_mask", 64'(spike_mask), 64'(exp_mask.pop_front()));
        end
      end
    end
  end

  task automatic load_mem();
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Issues one command; optional second start while busy and optional reset at a given cycle.
  task automatic run_cmd(input logic [4:0] b, input logic [4:0] ls, input int extra_at, input int abort_at);
    bit seen;
    seen = 1'b0;
    start = 1'b1;
    base = b;
    leak_shift = ls;
    push_expect(b, ls);
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
      end
      if (n == 2) chk("we_first_write_cycle", 64'(nsr_we), 64'd1);
      if (extra_at != 0 && n == extra_at) begin
        start = 1'b1;
        base = 5'($urandom);
        leak_shift = 5'($urandom);
      end
      if (extra_at != 0 && n == extra_at + 1) start = 1'b0;
      if (abort_at != 0 && n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_we", 64'(nsr_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mask", 64'(spike_mask), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b1;
      end else if (done) begin
        chk("latency", 64'(n), 64'd18);
        seen = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done within 40 cycles, expected done at cycle 18");
    end
  endtask

  task automatic fill(input logic [31:0] v, input logic [31:0] c);
    for (int i = 0; i < 32; i++) begin
      ld_vol[i] = v;
      ld_cur[i] = c;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      ld_vol[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 2000))) - 1000);
      ld_cur[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 400))) - 200);
    end
  endtask

  int d0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base = '0;
    leak_shift = '0;
    vt_in = '0;
    ld_en = 1'b0;
    fill(32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_we", 64'(nsr_we), 64'd0);
    chk("reset_wa", 64'(nsr_wa), 64'd0);
    chk("reset_wd", 64'(nsr_wd), 64'd0);
    chk("reset_ra", 64'(nsr_ra), 64'd0);
    chk("reset_mask", 64'(spike_mask), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    fill(32'd10, 32'd5);
    vt_in = 32'd100;
    load_mem();
    run_cmd(5'd0, 5'd31, 0, 0);

    fill(32'd0, 32'd0);
    ld_vol[3] = 32'd90;
    ld_cur[3] = 32'd20;
    load_mem();
    run_cmd(5'd0, 5'd31, 0, 0);

    fill(32'd64, 32'd0);
    load_mem();
    run_cmd(5'd0, 5'd2, 0, 0);

    fill(32'h7FFF_FFF0, 32'h0000_0100);
    vt_in = 32'h7FFF_FFFF;
    load_mem();
    run_cmd(5'd0, 5'd31, 0, 0);

    fill_random();
    vt_in = 32'd500;
    load_mem();
    run_cmd(5'd20, 5'($urandom), 0, 0);

    d0 = done_cnt;
    run_cmd(5'd7, 5'd3, 5, 0);
    repeat (25) @(posedge clk);
    #1;
    chk("single_done_with_ignored_start", 64'(done_cnt - d0), 64'd1);

    run_cmd(5'd0, 5'd4, 0, 8);
    run_cmd(5'd12, 5'd1, 0, 0);

    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        fill_random();
        vt_in = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 1500));
        load_mem();
      end
      run_cmd(5'($urandom), 5'($urandom), 0, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("expected_writes_drained", 64'(exp_wr.size()), 64'd0);
    chk("expected_masks_drained", 64'(exp_mask.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
